// File: rtl/rcvr_frame_filter.sv
// Receive frame filter: captures a 3-byte header, filters on destination address and
// buffers the payload speculatively, exposing it to the consumer only once the frame commits.
module rcvr_frame_filter #(
    parameter int         DEPTH       = 64,
    parameter logic [7:0] BCAST_ADDR  = 8'h2A,
    parameter int         BIT_REVERSE = 1,
    parameter int         CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               mac_addr,
    input  logic                     promisc,
    input  logic [7:0]               rx_data,
    input  logic                     rx_write,
    input  logic                     rx_error,
    input  logic                     rx_cardet,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               hdr_dest,
    output logic [7:0]               hdr_src,
    output logic [7:0]               hdr_type,
    output logic                     hdr_valid,
    output logic [CNT_W-1:0]         frame_ok_cnt,
    output logic [CNT_W-1:0]         frame_drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_t;

    state_t           r_state, w_state_next;
    logic             r_cardet;
    logic [1:0]       r_idx, w_idx_next;
    logic [PW-1:0]    r_wr_spec, r_wr_com, r_rd;
    logic [PW-1:0]    w_spec_next, w_com_next, w_rd_next, w_spec_inc;
    logic [7:0]       r_sh_dest, r_sh_src, r_sh_type;
    logic [7:0]       r_hdr_dest, r_hdr_src, r_hdr_type;
    logic             r_hdr_valid, r_out_valid;
    logic [PW-1:0]    r_level;
    logic [CNT_W-1:0] r_ok_cnt, r_drop_cnt;
    logic [7:0]       r_mem [DEPTH];

    logic [7:0] w_rev, w_byte;
    logic       w_rise, w_fall, w_full, w_match, w_cap;
    logic       w_mem_we, w_commit, w_drop;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rev
            assign w_rev[gi] = rx_data[7-gi];
        end
    endgenerate

    assign w_byte     = (BIT_REVERSE != 0) ? w_rev : rx_data;
    assign w_rise     = rx_cardet & ~r_cardet;
    assign w_fall     = ~rx_cardet & r_cardet;
    assign w_full     = (r_wr_spec - r_rd) == PW'(DEPTH);
    assign w_spec_inc = r_wr_spec + PW'(1);
    assign w_match    = (r_sh_dest == mac_addr) || (r_sh_dest == BCAST_ADDR) || promisc;
    assign w_cap      = (r_state == S_HDR) && rx_write && !rx_error;
    assign w_rd_next  = r_rd + PW'(r_out_valid && out_ready);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_spec_next  = r_wr_spec;
        w_com_next   = r_wr_com;
        w_mem_we     = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_HDR;
                    w_idx_next   = 2'd0;
                    w_spec_next  = r_wr_com;
                end
            end
            S_HDR: begin
                if (rx_error) begin
                    w_spec_next  = r_wr_com;
                    w_drop       = 1'b1;
                    w_state_next = S_DISCARD;
                end else if (rx_write && r_idx == 2'd2) begin
                    // Third header byte may arrive together with end of carrier: empty payload
                    if (!w_match)
                        w_state_next = w_fall ? S_IDLE : S_DISCARD;
                    else if (w_fall) begin
                        w_commit     = 1'b1;
                        w_state_next = S_IDLE;
                    end else
                        w_state_next = S_PAYLOAD;
                end else begin
                    if (rx_write)
                        w_idx_next = r_idx + 2'd1;
                    if (w_fall) begin
                        w_drop       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_error || (rx_write && w_full)) begin
                    w_spec_next  = r_wr_com;
                    w_drop       = 1'b1;
                    w_state_next = S_DISCARD;
                end else begin
                    w_mem_we = rx_write;
                    if (rx_write)
                        w_spec_next = w_spec_inc;
                    if (w_fall) begin
                        w_com_next   = rx_write ? w_spec_inc : r_wr_spec;
                        w_commit     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                if (!rx_cardet)
                    w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cardet    <= 1'b0;
            r_idx       <= '0;
            r_wr_spec   <= '0;
            r_wr_com    <= '0;
            r_rd        <= '0;
            r_sh_dest   <= '0;
            r_sh_src    <= '0;
            r_sh_type   <= '0;
            r_hdr_dest  <= '0;
            r_hdr_src   <= '0;
            r_hdr_type  <= '0;
            r_hdr_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_level     <= '0;
            r_ok_cnt    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cardet    <= rx_cardet;
            r_idx       <= w_idx_next;
            r_wr_spec   <= w_spec_next;
            r_wr_com    <= w_com_next;
            r_rd        <= w_rd_next;
            r_out_valid <= (w_com_next != w_rd_next);
            r_level     <= w_com_next - w_rd_next;
            r_hdr_valid <= w_commit;
            if (w_cap) begin
                case (r_idx)
                    2'd0:    r_sh_dest <= w_byte;
                    2'd1:    r_sh_src  <= w_byte;
                    default: r_sh_type <= w_byte;
                endcase
            end
            if (w_commit) begin
                r_hdr_dest <= r_sh_dest;
                r_hdr_src  <= r_sh_src;
                r_hdr_type <= (r_state == S_HDR) ? w_byte : r_sh_type;
            end
            if (w_commit && r_ok_cnt != '1)
                r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            if (w_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Payload storage carries no reset; only committed locations are ever read out
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_wr_spec[AW-1:0]] <= w_byte;
    end

    assign out_data       = r_mem[r_rd[AW-1:0]];
    assign out_valid      = r_out_valid;
    assign fifo_level     = r_level;
    assign hdr_dest       = r_hdr_dest;
    assign hdr_src        = r_hdr_src;
    assign hdr_type       = r_hdr_type;
    assign hdr_valid      = r_hdr_valid;
    assign frame_ok_cnt   = r_ok_cnt;
    assign frame_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_rcvr_frame_filter.sv
// Bench for rcvr_frame_filter: two instances (DEPTH 64 / CNT_W 8 and DEPTH 4 / CNT_W 3) share
// the stimulus and are compared every cycle against a queue-level frame model.
module tb_rcvr_frame_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, promisc, rx_write, rx_error, rx_cardet, out_ready;
    logic [7:0] mac_addr, rx_data;

    logic [7:0] a_data, a_hd, a_hs, a_ht, a_ok, a_drop;
    logic       a_valid, a_hv;
    logic [6:0] a_level;
    logic [7:0] b_data, b_hd, b_hs, b_ht;
    logic [2:0] b_ok, b_drop, b_level;
    logic       b_valid, b_hv;

    rcvr_frame_filter #(.DEPTH(64), .BCAST_ADDR(8'h2A), .BIT_REVERSE(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .mac_addr(mac_addr), .promisc(promisc),
        .rx_data(rx_data), .rx_write(rx_write), .rx_error(rx_error), .rx_cardet(rx_cardet),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .hdr_dest(a_hd), .hdr_src(a_hs), .hdr_type(a_ht), .hdr_valid(a_hv),
        .frame_ok_cnt(a_ok), .frame_drop_cnt(a_drop), .fifo_level(a_level));

    rcvr_frame_filter #(.DEPTH(4), .BCAST_ADDR(8'h2A), .BIT_REVERSE(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .mac_addr(mac_addr), .promisc(promisc),
        .rx_data(rx_data), .rx_write(rx_write), .rx_error(rx_error), .rx_cardet(rx_cardet),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .hdr_dest(b_hd), .hdr_src(b_hs), .hdr_type(b_ht), .hdr_valid(b_hv),
        .frame_ok_cnt(b_ok), .frame_drop_cnt(b_drop), .fifo_level(b_level));

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;
    int hv_seen[2];
    int dep[2]  = '{64, 4};
    int cmax[2] = '{255, 7};

    // model state: committed queue (circular), speculative bytes, header shadow, frame phase
    int         m_phase[2];            // 0 idle, 1 header, 2 payload, 3 discard
    logic [7:0] m_q[2][64];
    int         m_rd[2], m_cnt[2];
    logic [7:0] m_spec[2][64];
    int         m_sn[2];
    logic [7:0] m_sh[2][3];
    int         m_nh[2];
    logic [7:0] m_hd[2][3];
    int         m_hv[2], m_ok[2], m_drop[2];
    bit         m_prev_cd;

    int av[2], ad[2], al[2], ahv[2], ahd[2], ahs[2], aht[2], aok[2], adrop[2];
    logic [7:0] fb[32];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_rd[k] = 0; m_cnt[k] = 0; m_sn[k] = 0; m_nh[k] = 0;
            m_hv[k] = 0; m_ok[k] = 0; m_drop[k] = 0;
            for (int j = 0; j < 3; j++) m_hd[k][j] = 8'h00;
        end
        m_prev_cd = 1'b0;
    endtask

    task automatic model_step();
        bit rise, fall, pop, commit, drop, ovf, match;
        logic [7:0] b;
        b    = rev8(rx_data);
        rise = rx_cardet && !m_prev_cd;
        fall = !rx_cardet && m_prev_cd;
        for (int k = 0; k < 2; k++) begin
            pop = (m_cnt[k] > 0) && out_ready;
            commit = 0; drop = 0; ovf = 0;
            case (m_phase[k])
                0: if (rise) begin m_phase[k] = 1; m_nh[k] = 0; m_sn[k] = 0; end
                1: begin
                    if (rx_error) begin
                        drop = 1; m_phase[k] = 3;
                    end else begin
                        if (rx_write) begin m_sh[k][m_nh[k]] = b; m_nh[k]++; end
                        if (rx_write && m_nh[k] == 3) begin
                            match = (m_sh[k][0] == mac_addr) || (m_sh[k][0] == 8'h2A) || promisc;
                            if (!match) m_phase[k] = fall ? 0 : 3;
                            else if (fall) commit = 1;
                            else m_phase[k] = 2;
                        end else if (fall) begin
                            drop = 1; m_phase[k] = 0;
                        end
                    end
                end
                2: begin
                    if (rx_error) begin
                        drop = 1; m_sn[k] = 0; m_phase[k] = 3;
                    end else begin
                        if (rx_write) begin
                            if (m_cnt[k] + m_sn[k] < dep[k]) begin
                                m_spec[k][m_sn[k]] = b; m_sn[k]++;
                            end else begin
                                ovf = 1; drop = 1; m_sn[k] = 0; m_phase[k] = 3;
                            end
                        end
                        if (!ovf && fall) commit = 1;
                    end
                end
                default: if (!rx_cardet) m_phase[k] = 0;
            endcase
            m_hv[k] = commit;
            if (commit) begin
                for (int i = 0; i < m_sn[k]; i++) m_q[k][(m_rd[k] + m_cnt[k] + i) % 64] = m_spec[k][i];
                m_cnt[k] += m_sn[k];
                m_sn[k] = 0;
                for (int j = 0; j < 3; j++) m_hd[k][j] = m_sh[k][j];
                if (m_ok[k] < cmax[k]) m_ok[k]++;
                m_phase[k] = 0;
            end
            if (drop && m_drop[k] < cmax[k]) m_drop[k]++;
            if (pop) begin m_rd[k] = (m_rd[k] + 1) % 64; m_cnt[k]--; end
        end
        m_prev_cd = rx_cardet;
    endtask

    task automatic snap();
        av[0] = a_valid; ad[0] = a_data; al[0] = a_level; ahv[0] = a_hv;
        ahd[0] = a_hd; ahs[0] = a_hs; aht[0] = a_ht; aok[0] = a_ok; adrop[0] = a_drop;
        av[1] = b_valid; ad[1] = b_data; al[1] = b_level; ahv[1] = b_hv;
        ahd[1] = b_hd; ahs[1] = b_hs; aht[1] = b_ht; aok[1] = b_ok; adrop[1] = b_drop;
    endtask

    task automatic compare();
        snap();
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, av[k], (m_cnt[k] > 0) ? 1 : 0);
            if (m_cnt[k] > 0) chk("out_data", k, ad[k], m_q[k][m_rd[k]]);
            chk("fifo_level", k, al[k], m_cnt[k]);
            chk("hdr_valid", k, ahv[k], m_hv[k]);
            chk("hdr_dest", k, ahd[k], m_hd[k][0]);
            chk("hdr_src", k, ahs[k], m_hd[k][1]);
            chk("hdr_type", k, aht[k], m_hd[k][2]);
            chk("frame_ok_cnt", k, aok[k], m_ok[k]);
            chk("frame_drop_cnt", k, adrop[k], m_drop[k]);
            hv_seen[k] += ahv[k];
        end
    endtask

    task automatic cyc();
        if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (ready_mode == 1);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare();
    endtask

    task automatic send_frame(input int fn, input int err_at, input int gapmax, input bit coincide);
        int ng;
        rx_cardet = 1'b1;
        cyc();
        for (int i = 0; i < fn; i++) begin
            ng = $urandom_range(0, gapmax);
            for (int g = 0; g < ng; g++) cyc();
            rx_write = 1'b1;
            rx_data  = fb[i];
            rx_error = (i == err_at);
            if (coincide && i == fn - 1) rx_cardet = 1'b0;
            cyc();
            rx_write = 1'b0;
            rx_error = 1'b0;
        end
        rx_cardet = 1'b0;
        if (!(coincide && fn > 0)) cyc();
        cyc();
        cyc();
    endtask

    task automatic lit(input string name, input int k, input int act, input int exp);
        chk(name, k, act, exp);
    endtask

    initial begin
        int fn, err_at, d;
        bit coincide;
        logic [7:0] dest;
        rst = 1'b1; promisc = 1'b0; rx_write = 1'b0; rx_error = 1'b0; rx_cardet = 1'b0;
        out_ready = 1'b0; mac_addr = 8'h05; rx_data = 8'h00;
        hv_seen = '{0, 0};
        model_reset();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            lit("reset_valid", k, av[k], 0);
            lit("reset_level", k, al[k], 0);
            lit("reset_ok", k, aok[k], 0);
            lit("reset_hdr", k, ahd[k], 0);
        end

        // header A0 -> dest 05, payload 11,22 -> 88,44
        ready_mode = 0;
        fb[0] = 8'hA0; fb[1] = 8'h33; fb[2] = 8'h44; fb[3] = 8'h11; fb[4] = 8'h22;
        send_frame(5, -1, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit("lit_hdr_dest", k, ahd[k], 8'h05);
            lit("lit_hv_pulses", k, hv_seen[k], 1);
            lit("lit_level2", k, al[k], 2);
            lit("lit_first_byte", k, ad[k], 8'h88);
            lit("lit_ok1", k, aok[k], 1);
        end
        ready_mode = 1;
        cyc();
        for (int k = 0; k < 2; k++) lit("lit_second_byte", k, ad[k], 8'h44);
        cyc();
        for (int k = 0; k < 2; k++) lit("lit_drained", k, al[k], 0);

        // foreign destination dropped silently, then broadcast accepted
        ready_mode = 0;
        fb[0] = rev8(8'h07); fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h55; fb[4] = 8'h66;
        send_frame(5, -1, 1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit("lit_foreign_level", k, al[k], 0);
            lit("lit_foreign_ok", k, aok[k], 1);
            lit("lit_foreign_drop", k, adrop[k], 0);
        end
        fb[0] = rev8(8'h2A);
        send_frame(4, -1, 1, 1'b0);
        for (int k = 0; k < 2; k++) lit("lit_bcast_ok", k, aok[k], 2);
        ready_mode = 1;
        repeat (3) cyc();

        // error on payload byte 6 of 10 (DEPTH 4 instance overflows first)
        ready_mode = 0;
        fb[0] = 8'hA0; fb[1] = 8'h01; fb[2] = 8'h02;
        for (int i = 0; i < 10; i++) fb[3+i] = 8'(8'h10 + i);
        send_frame(13, 8, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit("lit_err_valid", k, av[k], 0);
            lit("lit_err_level", k, al[k], 0);
            lit("lit_err_drop", k, adrop[k], 1);
        end
        fb[3] = 8'h31; fb[4] = 8'h32; fb[5] = 8'h33;
        send_frame(6, -1, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit("lit_good_level", k, al[k], 3);
            lit("lit_good_data", k, ad[k], 8'h8C);
        end
        ready_mode = 1;
        repeat (5) cyc();

        // committed 2-byte frame retained when the next frame overflows DEPTH 4
        ready_mode = 0;
        fb[3] = 8'hC1; fb[4] = 8'hC2;
        send_frame(5, -1, 0, 1'b0);
        for (int i = 0; i < 5; i++) fb[3+i] = 8'(8'hD1 + i);
        send_frame(8, -1, 0, 1'b0);
        lit("lit_ovf_level", 0, al[0], 7);
        lit("lit_ovf_level", 1, al[1], 2);
        lit("lit_ovf_drop", 0, adrop[0], 1);
        lit("lit_ovf_drop", 1, adrop[1], 2);
        lit("lit_ovf_keep", 1, ad[1], rev8(8'hC1));
        ready_mode = 1;
        repeat (10) cyc();

        // asynchronous reset in the middle of a payload
        ready_mode = 0;
        rx_cardet = 1'b1;
        cyc();
        fb[3] = 8'hE1; fb[4] = 8'hE2;
        for (int i = 0; i < 5; i++) begin
            rx_write = 1'b1; rx_data = fb[i];
            cyc();
        end
        rx_write = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        for (int k = 0; k < 2; k++) begin
            lit("lit_rst_valid", k, av[k], 0);
            lit("lit_rst_level", k, al[k], 0);
            lit("lit_rst_ok", k, aok[k], 0);
            lit("lit_rst_hdr", k, ahd[k], 0);
        end
        rx_cardet = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        fb[3] = 8'h77;
        send_frame(4, -1, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit("lit_after_rst_level", k, al[k], 1);
            lit("lit_after_rst_ok", k, aok[k], 1);
        end

        // randomized frames with toggling out_ready; wraps pointers many times
        ready_mode = 2;
        for (int f = 0; f < 90; f++) begin
            fn = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 14);
            d = $urandom_range(0, 3);
            dest = (d == 0) ? 8'h05 : (d == 1) ? 8'h2A : (d == 2) ? 8'h07 : 8'($urandom);
            fb[0] = rev8(dest);
            for (int i = 1; i < 32; i++) fb[i] = 8'($urandom);
            promisc  = ($urandom_range(0, 6) == 0);
            err_at   = ($urandom_range(0, 7) == 0 && fn > 0) ? $urandom_range(0, fn - 1) : -1;
            coincide = ($urandom_range(0, 2) == 0);
            send_frame(fn, err_at, 2, coincide);
        end
        promisc = 1'b0;
        ready_mode = 1;
        repeat (70) cyc();
        for (int k = 0; k < 2; k++) lit("lit_final_level", k, al[k], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
